// File: rtl/carrier_nco_ddc.sv
// Carrier NCO + digital down-converter: rotates each valid complex sample by e^{-j*theta}.
// Latency: 3 cycles from in_valid_i to out_valid_o, one sample per cycle.
// Backpressure: none; the block always accepts a sample, and outputs hold their value while out_valid_o is low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   freq_word_i/_load_i phase increment and its load strobe
//   phase_clear_i       zero the phase accumulator
//   phase_latch_i       capture the accumulator into phase_snapshot_o
//   in_valid_i, in_i_i, in_q_i     signed input sample
//   out_valid_o, out_i_o, out_q_o  signed rotated sample, OUT_WIDTH bits
//
// Optional build macro CARRIER_NCO_DITHER_EN: adds LFSR phase dither to the
// lookup index only (the accumulator itself is never dithered).

module carrier_nco_ddc #(
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 6,
  parameter int AMP_MAX        = 12,
  parameter int IN_WIDTH       = 4,
  localparam int AMP_WIDTH     = $clog2(AMP_MAX + 1),
  localparam int OUT_WIDTH     = IN_WIDTH + AMP_WIDTH + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PHASE_WIDTH-1:0]      freq_word_i,
  input  logic                        freq_load_i,
  input  logic                        phase_clear_i,
  input  logic                        phase_latch_i,
  output logic [PHASE_WIDTH-1:0]      phase_snapshot_o,
  input  logic                        in_valid_i,
  input  logic signed [IN_WIDTH-1:0]  in_i_i,
  input  logic signed [IN_WIDTH-1:0]  in_q_i,
  output logic                        out_valid_o,
  output logic signed [OUT_WIDTH-1:0] out_i_o,
  output logic signed [OUT_WIDTH-1:0] out_q_o
);

  localparam int  L      = LUT_ADDR_WIDTH;
  localparam int  QN     = 2 ** (L - 2);
  localparam int  PROD_W = IN_WIDTH + AMP_WIDTH + 1;
  localparam real PI     = 3.14159265358979323846;

  // Quarter-wave table sampled at the centre of each phase bin:
  // q[k] = round(AMP_MAX * sin((2k+1)*pi/2^L)). Sine is evaluated with a
  // Taylor series so the table is fixed at elaboration time.
  function automatic logic [QN*AMP_WIDTH-1:0] build_qtable();
    logic [QN*AMP_WIDTH-1:0] t;
    real x;
    real term;
    real s;
    int  v;
    t = '0;
    for (int k = 0; k < QN; k++) begin
      x    = (2.0 * k + 1.0) * PI / (2.0 ** L);
      s    = 0.0;
      term = x;
      for (int n = 1; n < 12; n++) begin
        s    = s + term;
        term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
      end
      v = $rtoi(AMP_MAX * s + 0.5);
      t[k*AMP_WIDTH +: AMP_WIDTH] = AMP_WIDTH'(v);
    end
    return t;
  endfunction

  localparam logic [QN*AMP_WIDTH-1:0] QTABLE = build_qtable();

  // ---------------------------------------------------------------------------
  // Phase accumulator, frequency register, snapshot
  // ---------------------------------------------------------------------------
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] freq_reg;

  // Every sample and every snapshot sees the pre-update accumulator; a clear
  // wins over the increment, and a freq load only affects later samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc              <= '0;
      freq_reg         <= '0;
      phase_snapshot_o <= '0;
    end else begin
      if (phase_clear_i)
        acc <= '0;
      else if (in_valid_i)
        acc <= acc + freq_reg;
      if (freq_load_i)
        freq_reg <= freq_word_i;
      if (phase_latch_i)
        phase_snapshot_o <= acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup index (optionally dithered)
  // ---------------------------------------------------------------------------
  logic [L-1:0] lut_idx;

`ifdef CARRIER_NCO_DITHER_EN
  localparam int DITHER_W = (PHASE_WIDTH - L < 16) ? (PHASE_WIDTH - L) : 16;

  logic [15:0]         lfsr;
  logic [DITHER_W-1:0] dither;
  logic [DITHER_W-1:0] acc_mid;
  logic                dither_carry;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (in_valid_i)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // The dither lands directly below the lookup field, so its only effect on
  // the index is a carry; a + b overflows exactly when b > ~a.
  assign dither       = lfsr[15 -: DITHER_W];
  assign acc_mid      = acc[PHASE_WIDTH-L-1 -: DITHER_W];
  assign dither_carry = (dither > ~acc_mid);
  assign lut_idx      = acc[PHASE_WIDTH-1 -: L] + L'(dither_carry);
`else
  assign lut_idx = acc[PHASE_WIDTH-1 -: L];
`endif

  // ---------------------------------------------------------------------------
  // Quadrant folding into the quarter-wave table
  // ---------------------------------------------------------------------------
  logic [1:0]              quad;
  logic [L-3:0]            sin_addr;
  logic [L-3:0]            cos_addr;
  logic [AMP_WIDTH-1:0]    sin_mag;
  logic [AMP_WIDTH-1:0]    cos_mag;
  logic signed [AMP_WIDTH:0] sin_val;
  logic signed [AMP_WIDTH:0] cos_val;

  always_comb begin
    quad     = lut_idx[L-1 -: 2];
    // Odd quadrants run the table backwards.
    sin_addr = lut_idx[L-2] ? ~lut_idx[L-3:0] : lut_idx[L-3:0];
    // cos reads the mirrored entry: QN-1-addr == ~addr.
    cos_addr = ~sin_addr;
    sin_mag  = QTABLE[int'(sin_addr)*AMP_WIDTH +: AMP_WIDTH];
    cos_mag  = QTABLE[int'(cos_addr)*AMP_WIDTH +: AMP_WIDTH];
    sin_val  = quad[1]           ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
    cos_val  = (quad[1]^quad[0]) ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
  end

  // ---------------------------------------------------------------------------
  // Three-stage rotation pipeline
  // ---------------------------------------------------------------------------
  logic                      s1_vld;
  logic signed [AMP_WIDTH:0] s1_cos;
  logic signed [AMP_WIDTH:0] s1_sin;
  logic signed [IN_WIDTH-1:0] s1_i;
  logic signed [IN_WIDTH-1:0] s1_q;

  logic                     s2_vld;
  logic signed [PROD_W-1:0] s2_ic;
  logic signed [PROD_W-1:0] s2_qs;
  logic signed [PROD_W-1:0] s2_qc;
  logic signed [PROD_W-1:0] s2_is;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_cos      <= '0;
      s1_sin      <= '0;
      s1_i        <= '0;
      s1_q        <= '0;
      s2_vld      <= 1'b0;
      s2_ic       <= '0;
      s2_qs       <= '0;
      s2_qc       <= '0;
      s2_is       <= '0;
      out_valid_o <= 1'b0;
      out_i_o     <= '0;
      out_q_o     <= '0;
    end else begin
      s1_vld      <= in_valid_i;
      s2_vld      <= s1_vld;
      out_valid_o <= s2_vld;

      if (in_valid_i) begin
        s1_cos <= cos_val;
        s1_sin <= sin_val;
        s1_i   <= in_i_i;
        s1_q   <= in_q_i;
      end

      if (s1_vld) begin
        s2_ic <= PROD_W'(s1_i) * PROD_W'(s1_cos);
        s2_qs <= PROD_W'(s1_q) * PROD_W'(s1_sin);
        s2_qc <= PROD_W'(s1_q) * PROD_W'(s1_cos);
        s2_is <= PROD_W'(s1_i) * PROD_W'(s1_sin);
      end

      // Multiplying by e^{-j*theta}; OUT_WIDTH has headroom for the
      // worst-case sum so no saturation is required.
      if (s2_vld) begin
        out_i_o <= OUT_WIDTH'(s2_ic) + OUT_WIDTH'(s2_qs);
        out_q_o <= OUT_WIDTH'(s2_qc) - OUT_WIDTH'(s2_is);
      end
    end
  end

endmodule

// File: tb/tb_carrier_nco_ddc.sv
// Testbench for carrier_nco_ddc (default parameters, dither macro undefined).
// Directed vector table plus hand-written sequences for latency, clear/latch,
// freq-load timing and mid-stream reset.

module tb_carrier_nco_ddc;

  logic               clk;
  logic               rst;
  logic [31:0]        freq_word_i;
  logic               freq_load_i;
  logic               phase_clear_i;
  logic               phase_latch_i;
  logic [31:0]        phase_snapshot_o;
  logic               in_valid_i;
  logic signed [3:0]  in_i_i;
  logic signed [3:0]  in_q_i;
  logic               out_valid_o;
  logic signed [9:0]  out_i_o;
  logic signed [9:0]  out_q_o;

  int n_vec   = 0;
  int n_err   = 0;
  int tag_cnt = 0;

  typedef struct {
    bit chk;
    int tag;
    int ei;
    int eq;
  } exp_t;

  typedef struct {
    int idx;
    int in_i;
    int in_q;
    int ei;
    int eq;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[10];

  carrier_nco_ddc dut (
    .clk              (clk),
    .rst              (rst),
    .freq_word_i      (freq_word_i),
    .freq_load_i      (freq_load_i),
    .phase_clear_i    (phase_clear_i),
    .phase_latch_i    (phase_latch_i),
    .phase_snapshot_o (phase_snapshot_o),
    .in_valid_i       (in_valid_i),
    .in_i_i           (in_i_i),
    .in_q_i           (in_q_i),
    .out_valid_o      (out_valid_o),
    .out_i_o          (out_i_o),
    .out_q_o          (out_q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  // Reference rotation: bin-centre angle (2n+1)*pi/64, amplitude 12.
  task automatic model(input int idx, input int i, input int q, output int ei, output int eq);
    real ang;
    int  c;
    int  s;
    ang = (2.0 * (idx % 64) + 1.0) * 3.14159265358979 / 64.0;
    c   = rnd(12.0 * $cos(ang));
    s   = rnd(12.0 * $sin(ang));
    ei  = i * c + q * s;
    eq  = q * c - i * s;
  endtask

  // Output scoreboard: every out_valid_o pulse is matched in order.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid_o) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_output: got out_i=%0d out_q=%0d, expected no output", out_i_o, out_q_o);
      end else begin
        e = expq.pop_front();
        if (e.chk) begin
          check($sformatf("out_i[%0d]", e.tag), int'(out_i_o), e.ei);
          check($sformatf("out_q[%0d]", e.tag), int'(out_q_o), e.eq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid_i    = 1'b0;
    freq_load_i   = 1'b0;
    phase_clear_i = 1'b0;
    phase_latch_i = 1'b0;
  endtask

  task automatic send(input int i, input int q, input bit c, input int ei, input int eq);
    exp_t e;
    in_valid_i = 1'b1;
    in_i_i     = 4'(i);
    in_q_i     = 4'(q);
    e.chk = c;
    e.tag = tag_cnt;
    e.ei  = ei;
    e.eq  = eq;
    tag_cnt++;
    expq.push_back(e);
    tick();
  endtask

  // Leave acc = idx<<26 with freq_reg = idx<<26.
  task automatic set_phase(input int idx);
    freq_word_i   = 32'(idx) << 26;
    phase_clear_i = 1'b1;
    freq_load_i   = 1'b1;
    tick();
    send(0, 0, 1'b0, 0, 0);
  endtask

  // Called right after send(): valid must appear on the third edge only.
  task automatic lat_check(input string tag);
    @(negedge clk); check({tag, "_lat1"}, int'(out_valid_o), 0);
    @(negedge clk); check({tag, "_lat2"}, int'(out_valid_o), 0);
    @(negedge clk); check({tag, "_lat3"}, int'(out_valid_o), 1);
    @(negedge clk); check({tag, "_lat4"}, int'(out_valid_o), 0);
  endtask

  task automatic latch_check(input string tag, input int exp);
    phase_latch_i = 1'b1;
    tick();
    @(negedge clk);
    check(tag, int'(phase_snapshot_o), exp);
  endtask

  initial begin : main
    int ei;
    int eq;
    int pat_i[4];
    int pat_q[4];

    tbl[0] = '{0,   1,  0,   12,   -1};
    tbl[1] = '{0,  -8, -8, -104,  -88};
    tbl[2] = '{16,  1,  0,   -1,  -12};
    tbl[3] = '{32,  1,  0,  -12,    1};
    tbl[4] = '{8,   1,  0,    8,   -9};
    tbl[5] = '{48,  1,  0,    1,   12};
    tbl[6] = '{0,   7, -8,   76, -103};
    tbl[7] = '{24,  0,  1,    8,   -9};
    tbl[8] = '{40, -8,  7,    1, -128};
    tbl[9] = '{63, -8, -8,  -88, -104};

    pat_i = '{-8,  7, -8, 7};
    pat_q = '{-8, -8,  7, 7};

    rst           = 1'b1;
    freq_word_i   = '0;
    freq_load_i   = 1'b0;
    phase_clear_i = 1'b0;
    phase_latch_i = 1'b0;
    in_valid_i    = 1'b0;
    in_i_i        = '0;
    in_q_i        = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_out_i", int'(out_i_o), 0);
    check("rst_out_q", int'(out_q_o), 0);
    check("rst_snapshot", int'(phase_snapshot_o), 0);
    rst = 1'b0;
    tick();

    // First sample at phase 0 with freq loaded to 0 in the same cycle
    freq_word_i = '0;
    freq_load_i = 1'b1;
    send(1, 0, 1'b1, 12, -1);
    lat_check("first");
    latch_check("first_acc", 0);

    // Directed table
    for (int v = 0; v < 10; v++) begin
      set_phase(tbl[v].idx);
      send(tbl[v].in_i, tbl[v].in_q, 1'b1, tbl[v].ei, tbl[v].eq);
    end

    // Walk all 64 indices with (1,0), plus one more to show the wrap
    freq_word_i   = 32'h0400_0000;
    freq_load_i   = 1'b1;
    phase_clear_i = 1'b1;
    tick();
    for (int n = 0; n <= 64; n++) begin
      model(n, 1, 0, ei, eq);
      send(1, 0, 1'b1, ei, eq);
    end

    // Extreme inputs at every index
    for (int p = 0; p < 4; p++) begin
      phase_clear_i = 1'b1;
      tick();
      for (int n = 0; n < 64; n++) begin
        model(n, pat_i[p], pat_q[p], ei, eq);
        send(pat_i[p], pat_q[p], 1'b1, ei, eq);
      end
    end

    // Clear and latch in the same cycle as a sample at acc = 0x20000000
    freq_word_i   = 32'h2000_0000;
    freq_load_i   = 1'b1;
    phase_clear_i = 1'b1;
    tick();
    send(0, 0, 1'b0, 0, 0);
    phase_clear_i = 1'b1;
    phase_latch_i = 1'b1;
    send(1, 0, 1'b1, 8, -9);
    send(1, 0, 1'b1, 12, -1);
    @(negedge clk);
    check("clear_snapshot", int'(phase_snapshot_o), 32'h2000_0000);

    // freq load coincident with a sample only affects later samples
    freq_word_i   = '0;
    freq_load_i   = 1'b1;
    phase_clear_i = 1'b1;
    tick();
    freq_word_i = 32'h0400_0000;
    freq_load_i = 1'b1;
    send(1, 0, 1'b1, 12, -1);
    send(1, 0, 1'b1, 12, -1);
    send(1, 0, 1'b1, 12, -2);
    latch_check("load_timing_acc", 32'h0800_0000);

    // Undithered truncation: acc just below index 1 stays at index 0
    freq_word_i   = 32'h03FF_FFFF;
    freq_load_i   = 1'b1;
    phase_clear_i = 1'b1;
    tick();
    freq_word_i = '0;
    freq_load_i = 1'b1;
    send(0, 0, 1'b0, 0, 0);
    for (int n = 0; n < 4; n++) send(1, 0, 1'b1, 12, -1);
    latch_check("trunc_acc", 32'h03FF_FFFF);

    // Reset mid-burst with two samples still in the pipeline
    freq_word_i   = 32'h0400_0000;
    freq_load_i   = 1'b1;
    phase_clear_i = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      model(n, 1, 0, ei, eq);
      send(1, 0, 1'b1, ei, eq);
    end
    check("burst_valid_before_rst", int'(out_valid_o), 1);
    rst = 1'b1;
    #1;
    expq.delete();
    check("midrst_out_valid", int'(out_valid_o), 0);
    check("midrst_out_i", int'(out_i_o), 0);
    check("midrst_out_q", int'(out_q_o), 0);
    check("midrst_snapshot", int'(phase_snapshot_o), 0);
    repeat (4) begin
      @(negedge clk);
      check("midrst_hold_valid", int'(out_valid_o), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", int'(out_valid_o), 0);
    tick();
    // acc and freq_reg were both cleared, so two samples in a row sit at index 0
    send(1, 0, 1'b1, 12, -1);
    lat_check("post_rst");
    send(1, 0, 1'b1, 12, -1);
    latch_check("post_rst_acc", 0);

    // Drain
    for (int k = 0; k < 20 && expq.size() != 0; k++) @(negedge clk);
    check("drain_pending", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
